qif_scheduler: RTL and testbench
================================

QIF_SCHEDULER -- requirements
Module: qif_scheduler

Interface
REQ-001: Parameter N_NEURONS, default 8, number of time-multiplexed QIF neurons (power of 2, 2..16).
REQ-002: Parameter V_THRESH, default 50, signed 8-bit spike threshold.
REQ-003: Parameter V_RESET, default -20, signed 8-bit post-spike membrane value.
REQ-004: clk  input  1  single clock; all state updates on rising edge.
REQ-005: rst_n  input  1  reset, synchronous, active-high (asserted = 1 despite suffix).
REQ-006: start  input  1  one-cycle pulse requesting one update sweep over all neurons.
REQ-007: isyn_we  input  1  write enable for the synaptic current table.
REQ-008: isyn_waddr  input  log2(N_NEURONS)  neuron index written.
REQ-009: isyn_wdata  input  8  signed synaptic current.
REQ-010: rd_addr  input  log2(N_NEURONS)  membrane readout index.
REQ-011: rd_vmem  output  8  signed membrane value of neuron rd_addr, combinational read.
REQ-012: busy  output  1  high while a sweep is in progress.
REQ-013: done  output  1  one-cycle pulse at sweep completion.
REQ-014: spike_valid  output  1  one-cycle pulse when the neuron just updated fired.
REQ-015: spike_id  output  log2(N_NEURONS)  index of firing neuron, valid with spike_valid.

Function
REQ-016: Block SHALL hold per-neuron V[k] and I[k] tables, both signed 8-bit.
REQ-017: FSM states SHALL be IDLE, FETCH, UPDATE, DONE.
REQ-018: IDLE: start=1 -> FETCH with idx=0, busy=1 from next cycle; start=0 -> stay.
REQ-019: FETCH SHALL register V[idx] and I[idx] into operand registers, then -> UPDATE.
REQ-020: UPDATE SHALL write the result to V[idx]; if idx=N_NEURONS-1 -> DONE, else idx+1 and -> FETCH.
REQ-021: DONE SHALL pulse done for one cycle, drop busy, -> IDLE.
REQ-022: Latency: start accepted at cycle 0 -> done high at cycle 2*N_NEURONS+1 (17 for N=8).
REQ-023: Update rule: if V >= V_THRESH, new V = V_RESET and spike_valid=1, spike_id=idx in the UPDATE cycle.
REQ-024: Otherwise new V = V + (I>>>2) + (V>>>3)*(V>>>3), arithmetic shifts (floor), sum in >=11-bit signed, saturated to [-128,127].
REQ-025: Threshold compare SHALL use the pre-update V; no spike when the new V crosses threshold (fires on the next sweep).
REQ-026: start while busy SHALL be ignored; no queuing.
REQ-027: isyn_we SHALL be accepted in any state; a write to the index being fetched in the same cycle delivers the old I to FETCH, new I from the next sweep.
REQ-028: rd_vmem SHALL reflect the written V from the cycle after UPDATE.

Reset
REQ-029: rst_n=1 at a clock edge SHALL clear all V[k] and I[k] to 0, idx to 0, FSM to IDLE, busy/done/spike_valid/spike_id to 0.
REQ-030: Reset mid-sweep SHALL abort without completing the in-flight write-back and without a done pulse.

Structure
REQ-031: Shared package SHALL hold FSM state enum, default V_THRESH/V_RESET constants, and the 8-bit signed membrane type.
REQ-032: Update arithmetic SHALL be a combinational sub-module qif_update (inputs V, I; outputs new V, fire).

Verification
REQ-033: Reset then idle: every rd_addr reads 0, busy=0, done=0, spike_valid=0.
REQ-034: I[3]=8, two sweeps -> V[3]=2 then 4; other neurons stay 0; done at cycle 17 after each start.
REQ-035: I[3]=127, three sweeps -> V[3]=31, 71, then -20 with spike_valid=1, spike_id=3 in sweep 3.
REQ-036: V[5]=-20 reached, I[5]=0, one sweep -> V[5]=-11 (floor shift -3, square 9).
REQ-037: start pulsed again at cycles 3 and 10 of a sweep -> ignored, single done at cycle 17.
REQ-038: rst_n asserted at cycle 6 of a sweep -> all V=0, busy=0 next cycle, no done pulse.

Source files
------------

// File: rtl/qif_scheduler_pkg.sv
// qif_scheduler_pkg: shared types and defaults for the QIF neuron scheduler
package qif_scheduler_pkg;

    typedef logic signed [7:0] vmem_t;

    typedef enum logic [1:0] {IDLE, FETCH, UPDATE, DONE} state_t;

    localparam vmem_t V_THRESH_DEF = 8'sd50;
    localparam vmem_t V_RESET_DEF  = -8'sd20;

endpackage

// File: rtl/qif_scheduler_update.sv
// qif_update: combinational QIF membrane update for one neuron
//   v, i   : pre-update membrane value and synaptic current (signed 8-bit)
//   new_v  : post-update membrane value, saturated to signed 8-bit
//   fire   : pre-update v reached threshold; new_v is then the reset value
module qif_update
    import qif_scheduler_pkg::*;
#(
    parameter vmem_t V_THRESH = V_THRESH_DEF,
    parameter vmem_t V_RESET  = V_RESET_DEF
) (
    input  logic [7:0] v,
    input  logic [7:0] i,
    output logic [7:0] new_v,
    output logic       fire
);

    logic signed [10:0] ve, ie, vs, sum;

    always_comb begin
        ve    = {{3{v[7]}}, v};
        ie    = {{3{i[7]}}, i};
        vs    = ve >>> 3;
        // worst case 127 + 31 + 256 stays well inside 11-bit signed range
        sum   = ve + (ie >>> 2) + vs * vs;
        fire  = $signed(v) >= V_THRESH;
        new_v = fire ? V_RESET :
                (sum > 11'sd127)  ? 8'h7f :
                (sum < -11'sd128) ? 8'h80 : sum[7:0];
    end

endmodule

// File: rtl/qif_scheduler.sv
// qif_scheduler: time-multiplexed sweep over N_NEURONS QIF neurons
//   clk, rst_n        : clock; synchronous reset, active HIGH despite the name
//   start             : request one sweep (ignored while a sweep runs)
//   isyn_we/waddr/wdata : synaptic current table write port
//   rd_addr / rd_vmem : combinational membrane readout
//   busy, done        : sweep in progress (FETCH/UPDATE), one-cycle completion pulse
//   spike_valid/id    : neuron updated this cycle fired
module qif_scheduler
    import qif_scheduler_pkg::*;
#(
    parameter int    N_NEURONS = 8,
    parameter vmem_t V_THRESH  = V_THRESH_DEF,
    parameter vmem_t V_RESET   = V_RESET_DEF,
    localparam int   AW        = $clog2(N_NEURONS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          isyn_we,
    input  logic [AW-1:0] isyn_waddr,
    input  logic [7:0]    isyn_wdata,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_vmem,
    output logic          busy,
    output logic          done,
    output logic          spike_valid,
    output logic [AW-1:0] spike_id
);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    vmem_t         va_q, va_d, ia_q, ia_d;
    vmem_t         v_q [N_NEURONS];
    vmem_t         v_d [N_NEURONS];
    vmem_t         i_q [N_NEURONS];
    vmem_t         i_d [N_NEURONS];
    logic [7:0]    new_v;
    logic          fire;

    qif_update #(.V_THRESH(V_THRESH), .V_RESET(V_RESET)) u_update (
        .v     (va_q),
        .i     (ia_q),
        .new_v (new_v),
        .fire  (fire)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        va_d    = va_q;
        ia_d    = ia_q;
        v_d     = v_q;
        i_d     = i_q;
        // FETCH samples i_q, so a same-cycle write to that index lands next sweep
        if (isyn_we) i_d[isyn_waddr] = isyn_wdata;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    idx_d   = '0;
                end
            end
            FETCH: begin
                va_d    = v_q[idx_q];
                ia_d    = i_q[idx_q];
                state_d = UPDATE;
            end
            UPDATE: begin
                v_d[idx_q] = new_v;
                state_d    = (idx_q == AW'(N_NEURONS - 1)) ? DONE : FETCH;
                idx_d      = (idx_q == AW'(N_NEURONS - 1)) ? idx_q : idx_q + AW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            va_q    <= '0;
            ia_q    <= '0;
            v_q     <= '{default: '0};
            i_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            va_q    <= va_d;
            ia_q    <= ia_d;
            v_q     <= v_d;
            i_q     <= i_d;
        end
    end

    assign rd_vmem     = v_q[rd_addr];
    assign busy        = (state_q == FETCH) || (state_q == UPDATE);
    assign done        = state_q == DONE;
    assign spike_valid = (state_q == UPDATE) && fire;
    assign spike_id    = spike_valid ? idx_q : '0;

endmodule

// File: tb/tb_qif_scheduler.sv
// tb_qif_scheduler: directed self-checking bench for qif_scheduler
module tb_qif_scheduler;

    logic              clk = 0;
    logic              rst_n = 0;
    logic              start = 0;
    logic              isyn_we = 0;
    logic [2:0]        isyn_waddr = 0;
    logic [7:0]        isyn_wdata = 0;
    logic [2:0]        rd_addr = 0;
    logic signed [7:0] rd_vmem;
    logic              busy, done, spike_valid;
    logic [2:0]        spike_id;

    int errs = 0;
    int chks = 0;
    int dcyc, ndone, nspk, sid;
    logic busy1;
    logic signed [7:0] v8, v9, rv;

    qif_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .isyn_we     (isyn_we),
        .isyn_waddr  (isyn_waddr),
        .isyn_wdata  (isyn_wdata),
        .rd_addr     (rd_addr),
        .rd_vmem     (rd_vmem),
        .busy        (busy),
        .done        (done),
        .spike_valid (spike_valid),
        .spike_id    (spike_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1;
        tick();
        rst_n = 0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        isyn_we = 1; isyn_waddr = a; isyn_wdata = d;
        tick();
        isyn_we = 0;
    endtask

    task automatic rdv(input logic [2:0] a, output logic signed [7:0] v);
        rd_addr = a;
        #1;
        v = rd_vmem;
    endtask

    // Runs one sweep for a fixed 20-cycle window; cycle 1 is the first FETCH.
    // pa/pb: cycles with an extra start pulse; wc: cycle with an isyn write.
    task automatic sweep(input int pa, input int pb, input int wc,
                         input logic [2:0] wa, input logic [7:0] wd);
        dcyc = 0; ndone = 0; nspk = 0; sid = -1; busy1 = 0; v8 = 0; v9 = 0;
        start = 1;
        tick();
        for (int c = 1; c <= 20; c++) begin
            start = (c == pa) || (c == pb);
            isyn_we = (c == wc); isyn_waddr = wa; isyn_wdata = wd;
            rd_addr = 3;
            #1;
            if (done) begin ndone++; if (dcyc == 0) dcyc = c; end
            if (spike_valid) begin nspk++; sid = int'(spike_id); end
            if (c == 1) busy1 = busy;
            if (c == 8) v8 = rd_vmem;
            if (c == 9) v9 = rd_vmem;
            tick();
        end
        start = 0; isyn_we = 0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int a = 0; a < 8; a++) begin
            rdv(3'(a), rv);
            chks++; if (rv !== 8'sd0) begin errs++; $display("FAIL reset_v[%0d] got %0d exp 0", a, rv); end
        end
        chks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", busy); end
        chks++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %b exp 0", done); end
        chks++; if (spike_valid !== 1'b0) begin errs++; $display("FAIL reset_spike got %b exp 0", spike_valid); end
    endtask

    task automatic test_drive();
        do_reset();
        wr(3, 8);
        sweep(-1, -1, -1, 0, 0);
        chks++; if (busy1 !== 1'b1) begin errs++; $display("FAIL drive_busy1 got %b exp 1", busy1); end
        chks++; if (dcyc != 17) begin errs++; $display("FAIL drive_done_cycle got %0d exp 17", dcyc); end
        chks++; if (ndone != 1) begin errs++; $display("FAIL drive_done_count got %0d exp 1", ndone); end
        chks++; if (v8 !== 8'sd0) begin errs++; $display("FAIL drive_v3_c8 got %0d exp 0", v8); end
        chks++; if (v9 !== 8'sd2) begin errs++; $display("FAIL drive_v3_c9 got %0d exp 2", v9); end
        for (int a = 0; a < 8; a++) begin
            rdv(3'(a), rv);
            chks++; if (rv !== ((a == 3) ? 8'sd2 : 8'sd0)) begin errs++; $display("FAIL drive1_v[%0d] got %0d exp %0d", a, rv, (a == 3) ? 2 : 0); end
        end
        sweep(-1, -1, -1, 0, 0);
        chks++; if (dcyc != 17) begin errs++; $display("FAIL drive2_done_cycle got %0d exp 17", dcyc); end
        rdv(3, rv);
        chks++; if (rv !== 8'sd4) begin errs++; $display("FAIL drive2_v3 got %0d exp 4", rv); end
        rdv(2, rv);
        chks++; if (rv !== 8'sd0) begin errs++; $display("FAIL drive2_v2 got %0d exp 0", rv); end
    endtask

    task automatic test_spike();
        do_reset();
        wr(3, 127);
        sweep(-1, -1, -1, 0, 0);
        rdv(3, rv);
        chks++; if (rv !== 8'sd31) begin errs++; $display("FAIL spike_s1_v3 got %0d exp 31", rv); end
        chks++; if (nspk != 0) begin errs++; $display("FAIL spike_s1_count got %0d exp 0", nspk); end
        sweep(-1, -1, -1, 0, 0);
        rdv(3, rv);
        chks++; if (rv !== 8'sd71) begin errs++; $display("FAIL spike_s2_v3 got %0d exp 71", rv); end
        chks++; if (nspk != 0) begin errs++; $display("FAIL spike_s2_count got %0d exp 0", nspk); end
        sweep(-1, -1, -1, 0, 0);
        rdv(3, rv);
        chks++; if (rv !== -8'sd20) begin errs++; $display("FAIL spike_s3_v3 got %0d exp -20", rv); end
        chks++; if (nspk != 1) begin errs++; $display("FAIL spike_s3_count got %0d exp 1", nspk); end
        chks++; if (sid != 3) begin errs++; $display("FAIL spike_s3_id got %0d exp 3", sid); end
    endtask

    task automatic test_negative();
        do_reset();
        wr(5, 127);
        for (int s = 0; s < 3; s++) sweep(-1, -1, -1, 0, 0);
        rdv(5, rv);
        chks++; if (rv !== -8'sd20) begin errs++; $display("FAIL neg_v5_pre got %0d exp -20", rv); end
        wr(5, 0);
        sweep(-1, -1, -1, 0, 0);
        rdv(5, rv);
        chks++; if (rv !== -8'sd11) begin errs++; $display("FAIL neg_v5 got %0d exp -11", rv); end
    endtask

    task automatic test_ignore_start();
        do_reset();
        sweep(3, 10, -1, 0, 0);
        chks++; if (ndone != 1) begin errs++; $display("FAIL ignore_done_count got %0d exp 1", ndone); end
        chks++; if (dcyc != 17) begin errs++; $display("FAIL ignore_done_cycle got %0d exp 17", dcyc); end
        chks++; if (busy !== 1'b0) begin errs++; $display("FAIL ignore_busy_after got %b exp 0", busy); end
    endtask

    task automatic test_isyn_collision();
        do_reset();
        // cycle 1 is FETCH of neuron 0: the write must not reach this sweep
        sweep(-1, -1, 1, 0, 127);
        rdv(0, rv);
        chks++; if (rv !== 8'sd0) begin errs++; $display("FAIL coll_v0_s1 got %0d exp 0", rv); end
        sweep(-1, -1, -1, 0, 0);
        rdv(0, rv);
        chks++; if (rv !== 8'sd31) begin errs++; $display("FAIL coll_v0_s2 got %0d exp 31", rv); end
    endtask

    task automatic test_reset_mid();
        int nd;
        do_reset();
        wr(0, 127);
        start = 1;
        tick();
        start = 0;
        for (int c = 1; c < 6; c++) tick();
        rdv(0, rv);
        chks++; if (rv !== 8'sd31) begin errs++; $display("FAIL mid_v0_before got %0d exp 31", rv); end
        rst_n = 1;
        tick();
        rst_n = 0;
        chks++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy got %b exp 0", busy); end
        for (int a = 0; a < 8; a++) begin
            rdv(3'(a), rv);
            chks++; if (rv !== 8'sd0) begin errs++; $display("FAIL mid_v[%0d] got %0d exp 0", a, rv); end
        end
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) nd++;
            tick();
        end
        chks++; if (nd != 0) begin errs++; $display("FAIL mid_done_count got %0d exp 0", nd); end
        sweep(-1, -1, -1, 0, 0);
        rdv(0, rv);
        chks++; if (rv !== 8'sd0) begin errs++; $display("FAIL mid_i_cleared_v0 got %0d exp 0", rv); end
    endtask

    initial begin
        test_reset();
        test_drive();
        test_spike();
        test_negative();
        test_ignore_start();
        test_isyn_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
